imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader.sv | 151 +++++++++++++++
 tb/tb_imem_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - streams a program into instruction memory, then releases the core
//
// Ports:
//   clk, rst                 rising-edge clock, asynchronous active-low reset
//   in_valid/in_data/in_last program word stream (accepted on in_valid && in_ready)
//   in_ready                 high only while loading
//   reload                   restart a load; honoured only while the core runs
//   imem_we/addr/wdata       one-cycle write strobe, issued the cycle after each accept
//   core_rst                 active-low core reset, released RST_HOLD cycles after the last write
//   done                     program loaded and core running
//   overflow                 sticky: DEPTH words arrived without in_last
//   word_count               words accepted in the current load
module imem_loader #(
    parameter int unsigned DEPTH     = 1024,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter int unsigned RST_HOLD  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [31:0]              in_data,
    input  logic                     in_last,
    output logic                     in_ready,
    input  logic                     reload,
    output logic                     imem_we,
    output logic [31:0]              imem_addr,
    output logic [31:0]              imem_wdata,
    output logic                     core_rst,
    output logic                     done,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   word_count
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int HW = $clog2(RST_HOLD + 1);

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_HOLD,
        ST_RUN
    } state_t;

    state_t          state_q, state_d;
    logic            in_ready_q, in_ready_d;
    logic            imem_we_q, imem_we_d;
    logic [31:0]     imem_addr_q, imem_addr_d;
    logic [31:0]     imem_wdata_q, imem_wdata_d;
    logic            core_rst_q, core_rst_d;
    logic            done_q, done_d;
    logic            overflow_q, overflow_d;
    logic [CW-1:0]   word_count_q, word_count_d;
    logic [HW-1:0]   hold_cnt_q, hold_cnt_d;

    logic accept;

    // in_ready_q is only ever high while in LOAD, so it alone qualifies an accept
    // and in_valid is naturally ignored in HOLD and RUN.
    assign accept = in_valid && in_ready_q;

    always_comb begin
        state_d      = state_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        core_rst_d   = core_rst_q;
        done_d       = done_q;
        overflow_d   = overflow_q;
        word_count_d = word_count_q;
        hold_cnt_d   = hold_cnt_q;

        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    // word_count before the increment is the index of this word
                    imem_we_d    = 1'b1;
                    imem_addr_d  = BASE_ADDR + (32'(word_count_q) << 2);
                    imem_wdata_d = in_data;
                    word_count_d = word_count_q + 1'b1;
                    if (in_last || (word_count_q == CW'(DEPTH - 1))) begin
                        state_d    = ST_HOLD;
                        overflow_d = !in_last;
                        hold_cnt_d = '0;
                    end
                end
            end
            ST_HOLD: begin
                // The first HOLD cycle carries the final write strobe; the counter
                // then runs through RST_HOLD further cycles before release.
                if (hold_cnt_q == HW'(RST_HOLD)) begin
                    state_d    = ST_RUN;
                    core_rst_d = 1'b1;
                    done_d     = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            ST_RUN: begin
                if (reload) begin
                    state_d      = ST_LOAD;
                    core_rst_d   = 1'b0;
                    done_d       = 1'b0;
                    word_count_d = '0;
                    overflow_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase

        // Registered ready follows the next state, so it rises on the first edge
        // after reset and drops in the cycle after the final accept.
        in_ready_d = (state_d == ST_LOAD);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_LOAD;
            in_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            core_rst_q   <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            word_count_q <= '0;
            hold_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            core_rst_q   <= core_rst_d;
            done_q       <= done_d;
            overflow_q   <= overflow_d;
            word_count_q <= word_count_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign in_ready   = in_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign core_rst   = core_rst_q;
    assign done       = done_q;
    assign overflow   = overflow_q;
    assign word_count = word_count_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
module tb_imem_loader;

    localparam int unsigned TB_DEPTH = 4;
    localparam logic [31:0] TB_BASE  = 32'h0000_0100;
    localparam int unsigned TB_HOLD  = 4;

    logic                        clk = 1'b0;
    logic                        rst;
    logic                        in_valid;
    logic [31:0]                 in_data;
    logic                        in_last;
    logic                        in_ready;
    logic                        reload;
    logic                        imem_we;
    logic [31:0]                 imem_addr;
    logic [31:0]                 imem_wdata;
    logic                        core_rst;
    logic                        done;
    logic                        overflow;
    logic [$clog2(TB_DEPTH):0]   word_count;

    imem_loader #(
        .DEPTH     (TB_DEPTH),
        .BASE_ADDR (TB_BASE),
        .RST_HOLD  (TB_HOLD)
    ) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .reload     (reload),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .core_rst   (core_rst),
        .done       (done),
        .overflow   (overflow),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: event timeline of the load, in plain arithmetic.
    int          m_edge;
    int          m_release;
    int          m_cnt;
    bit          m_fresh, m_ready, m_we, m_core, m_done, m_ovf, m_run;
    logic [31:0] m_addr, m_wdata;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_edge    = 0;
        m_release = -1;
        m_cnt     = 0;
        m_fresh   = 1'b1;
        m_ready   = 1'b0;
        m_we      = 1'b0;
        m_core    = 1'b0;
        m_done    = 1'b0;
        m_ovf     = 1'b0;
        m_run     = 1'b0;
        m_addr    = '0;
        m_wdata   = '0;
    endtask

    task automatic model_step(input bit v, input logic [31:0] d, input bit l, input bit r);
        bit acc;
        m_edge++;
        acc  = v && m_ready;
        m_we = acc;
        if (acc) begin
            m_addr  = TB_BASE + 32'(m_cnt * 4);
            m_wdata = d;
            m_cnt++;
            if (l || m_cnt == int'(TB_DEPTH)) begin
                m_ready = 1'b0;
                if (!l) m_ovf = 1'b1;
                // strobe cycle, then TB_HOLD held cycles, then release
                m_release = m_edge + int'(TB_HOLD) + 1;
            end
        end else if (m_run && r) begin
            m_run   = 1'b0;
            m_core  = 1'b0;
            m_done  = 1'b0;
            m_cnt   = 0;
            m_ovf   = 1'b0;
            m_ready = 1'b1;
        end
        if (m_fresh) begin
            m_fresh = 1'b0;
            m_ready = 1'b1;
        end
        if (m_release == m_edge) begin
            m_run     = 1'b1;
            m_core    = 1'b1;
            m_done    = 1'b1;
            m_release = -1;
        end
    endtask

    task automatic check_all();
        chk("in_ready",   in_ready,   m_ready);
        chk("imem_we",    imem_we,    m_we);
        chk("imem_addr",  imem_addr,  m_addr);
        chk("imem_wdata", imem_wdata, m_wdata);
        chk("core_rst",   core_rst,   m_core);
        chk("done",       done,       m_done);
        chk("overflow",   overflow,   m_ovf);
        chk("word_count", 32'(word_count), 32'(m_cnt));
    endtask

    // Called at a negedge; drives inputs, steps the model at the posedge,
    // compares at the following negedge.
    task automatic cycle(input bit v, input logic [31:0] d, input bit l, input bit r);
        in_valid = v;
        in_data  = d;
        in_last  = l;
        reload   = r;
        @(posedge clk);
        model_step(v, d, l, r);
        @(negedge clk);
        check_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 32'h0, 1'b0, 1'b0);
    endtask

    // Asynchronous reset asserted between edges; outputs must clear at once.
    task automatic do_reset();
        #2;
        rst      = 1'b0;
        in_valid = 1'b0;
        in_last  = 1'b0;
        reload   = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] prog [3];
        prog[0] = 32'h0050_0293;
        prog[1] = 32'h0030_0313;
        prog[2] = 32'h0062_83B3;

        rst      = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        reload   = 1'b0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // reload while loading must be ignored
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        idle(1);

        // three-word program, last on the third
        for (int i = 0; i < 3; i++) cycle(1'b1, prog[i], i == 2, 1'b0);
        idle(8);

        // in_valid held in RUN, then reload with gapped stream 1,0,0,1,1
        for (int i = 0; i < 4; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        cycle(1'b1, $urandom, 1'b0, 1'b0);
        idle(2);
        cycle(1'b1, $urandom, 1'b0, 1'b0);
        cycle(1'b1, $urandom, 1'b1, 1'b0);
        // in_valid held through HOLD and into RUN
        for (int i = 0; i < 10; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);

        // overflow: five words offered, in_last never set
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
        idle(7);

        // reset after two accepted words, then a single-word load
        cycle(1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) cycle(1'b1, $urandom, 1'b0, 1'b0);
        do_reset();
        cycle(1'b0, 32'h0, 1'b0, 1'b0);
        cycle(1'b1, 32'hCAFE_F00D, 1'b1, 1'b0);
        idle(7);

        // randomized traffic with occasional reloads and resets
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 249) == 0) do_reset();
            cycle($urandom_range(0, 3) != 0, $urandom,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 7) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
